siso_line_ctrl: RTL and testbench
=================================

Name: siso_line_ctrl

Overview:
Sequencer for the team's DEPTH-stage serial-in/serial-out shift line.
- Accepts a WIDTH-bit parallel word through a valid/ready handshake.
- Drives the word into the line LSB-first on sr_d.
- Samples the bits returning on sr_q after the line latency and presents the reassembled word through a second valid/ready handshake.
- Flushes the line after reset so stale bits never reach the output.
- Sits between a parallel requester and the serial line. It is used for line loopback/delay and integrity checks.

Parameters:
WIDTH, 6, bits per word (≥1)
DEPTH, 6, number of flops in the external serial line (≥1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
in_valid  input  1  requester presents in_data
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  word to send
out_valid  output  1  out_data holds a completed word
out_ready  input  1  consumer takes out_data
out_data  output  WIDTH  reassembled word
sr_d  output  WIDTH=1  registered serial drive into the line input
sr_q  input  1  serial line output
busy  output  1  high whenever state != IDLE

Behaviour:
- States: FLUSH, IDLE, RUN, DONE. State is encoded in a registered enum.
- Reset (reset=0 at a clk edge) produces:
  - state=FLUSH, cnt=0, sr_d=0, out_valid=0, out_data=0, tx/rx shift registers=0.
  - in_ready=0 and busy=1.
- FLUSH:
  - sr_d is held at 0 for DEPTH cycles after reset deasserts, which clears the line.
  - Then the block goes to IDLE.
  - For DEPTH=6, in_ready first reads 1 in the 7th cycle after reset is released.
- IDLE:
  - in_ready=1 (decoded from registered state) and sr_d=0.
  - Accept edge E0 is an edge with in_valid&&in_ready. At E0: tx<=in_data, sr_d<=in_data[0], cnt<=1, go to RUN.
- RUN (cnt counts edges after E0, width $clog2(WIDTH+DEPTH+1)):
  - Drive: at edge E0+i, for 1≤i≤WIDTH-1, sr_d<=in_data[i]. At E0+WIDTH and later, sr_d<=0.
  - Sample: bit i sits at sr_q during the cycle after edge E0+i+DEPTH. It is captured at edge E0+i+DEPTH+1 with rx<={sr_q, rx[WIDTH-1:1]}.
  - At edge E0+WIDTH+DEPTH the final bit is captured: out_data<=completed rx, out_valid<=1, go to DONE.
  - Latency from accept edge to out_valid=1 is WIDTH+DEPTH cycles (12 at defaults).
- DONE:
  - out_valid=1, with out_data and sr_d=0 held stable.
  - in_ready=0, so in_valid is ignored.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. in_ready is 1 in the next cycle.
  - out_ready arriving in the same cycle as a new in_valid does not accept the new word. Acceptance waits for IDLE.
- Only one word is in flight at a time. in_data is ignored except at the accept edge.
- Reset mid-RUN/DONE: the word is abandoned (no out_valid) and the block re-enters FLUSH. Stale line contents are purged before the next accept.
- out_ready in IDLE/RUN/FLUSH has no effect.

Decomposition:
- Shared package siso_ctrl_pkg:
  - state enum (FLUSH, IDLE, RUN, DONE)
  - default WIDTH/DEPTH constants
  - cnt width function
- No sub-module is required; tx and rx shifters are inline.
- The bench instantiates the team's existing DEPTH-stage SISO line between sr_d and sr_q.

Test Plan:
1. Reset 3 cycles, then release -> in_ready=0 for exactly 6 cycles, then 1. sr_d=0 throughout.
2. Accept 6'b101101 -> sr_d sequence 1,0,1,1,0,1 on edges E0..E0+5. out_valid rises at E0+12 with out_data=6'b101101.
3. Same word with out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held, in_ready=0. Release at the 6th cycle -> in_ready=1 in the next cycle.
4. Accept 6'h15, assert reset at E0+4 for 1 cycle -> out_valid never rises, FLUSH lasts 6 cycles. Then accept 6'h2A -> out_data=6'h2A with no corruption.
5. Send 6'h00 then 6'h3F with in_valid and out_ready held at 1 -> both returned exactly. Second accept occurs 2 cycles after the first out_valid rise.
6. WIDTH=8, DEPTH=3, word 8'hA5 -> flush lasts 3 cycles, out_valid at E0+11, out_data=8'hA5.

Source files
------------

// File: rtl/siso_ctrl_pkg.sv
// Shared types and constants for the serial-in/serial-out line sequencer.
package siso_ctrl_pkg;

  parameter int unsigned DefWidth = 6;
  parameter int unsigned DefDepth = 6;

  typedef enum logic [1:0] {
    StFlush,
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter must reach WIDTH+DEPTH, the edge on which the last bit is captured.
  function automatic int unsigned cnt_width(int unsigned width, int unsigned depth);
    return $clog2(width + depth + 1);
  endfunction

endpackage

// File: rtl/siso_line_ctrl_if.sv
// Parallel word handshakes between requester/consumer and the line sequencer.
interface siso_line_ctrl_if #(
  parameter int unsigned WIDTH = siso_ctrl_pkg::DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/siso_line_ctrl.sv
// Sends one word LSB-first through an external DEPTH-stage serial line and
// reassembles the returning bits into a word; flushes the line after reset.
module siso_line_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             reset,
  siso_line_ctrl_if.slave  bus,
  output logic             sr_d,
  input  logic             sr_q,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH, DEPTH);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  rx_shift;
  logic              sr_d_q, sr_d_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;

  // Returning bits enter at the MSB so the first bit sent ends up at bit 0.
  always_comb begin
    rx_shift            = rx_q >> 1;
    rx_shift[WIDTH-1]   = sr_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sr_d_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StFlush: begin
        if (cnt_q == CntW'(DEPTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (bus.in_valid) begin
          // tx holds the bits still to be driven; it drains to zero.
          tx_d    = bus.in_data >> 1;
          sr_d_d  = bus.in_data[0];
          cnt_d   = CntW'(1);
          state_d = StRun;
        end
      end
      StRun: begin
        sr_d_d = tx_q[0];
        tx_d   = tx_q >> 1;
        rx_d   = rx_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH + DEPTH)) begin
          out_data_d  = rx_shift;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StFlush;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      sr_d_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sr_d_q      <= sr_d_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign sr_d          = sr_d_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_siso_line_ctrl.sv
// Bench for siso_line_ctrl: two configurations, each looped through a model SISO line.
module tb_siso_line_ctrl;

  localparam int unsigned WA = 6;
  localparam int unsigned DA = 6;
  localparam int unsigned WB = 8;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  logic sr_d_a, sr_q_a, busy_a;
  logic sr_d_b, sr_q_b, busy_b;
  logic [DA-1:0] line_a;
  logic [DB-1:0] line_b;

  int vectors = 0;
  int miscompares = 0;

  siso_line_ctrl_if #(.WIDTH(WA)) bus_a ();
  siso_line_ctrl_if #(.WIDTH(WB)) bus_b ();

  siso_line_ctrl #(.WIDTH(WA), .DEPTH(DA)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a),
    .sr_d  (sr_d_a),
    .sr_q  (sr_q_a),
    .busy  (busy_a)
  );

  siso_line_ctrl #(.WIDTH(WB), .DEPTH(DB)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b),
    .sr_d  (sr_d_b),
    .sr_q  (sr_q_b),
    .busy  (busy_b)
  );

  // External serial lines: plain shift registers with no reset.
  always @(posedge clk) begin
    line_a <= {line_a[DA-2:0], sr_d_a};
    line_b <= {line_b[DB-2:0], sr_d_b};
  end
  assign sr_q_a = line_a[DA-1];
  assign sr_q_b = line_b[DB-1];

  task automatic test_reset();
    reset_a = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus_a.in_ready !== 1'b0) begin miscompares++;
      $display("FAIL rst_in_ready: got %b want 0", bus_a.in_ready); end
    vectors++; if (busy_a !== 1'b1) begin miscompares++;
      $display("FAIL rst_busy: got %b want 1", busy_a); end
    vectors++; if (bus_a.out_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); end
    vectors++; if (bus_a.out_data !== '0) begin miscompares++;
      $display("FAIL rst_out_data: got %h want 0", bus_a.out_data); end
    vectors++; if (sr_d_a !== 1'b0) begin miscompares++;
      $display("FAIL rst_sr_d: got %b want 0", sr_d_a); end
    reset_a = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      vectors++; if (bus_a.in_ready !== (c >= 7)) begin miscompares++;
        $display("FAIL flush_in_ready c=%0d: got %b want %b", c, bus_a.in_ready, c >= 7); end
      vectors++; if (sr_d_a !== 1'b0) begin miscompares++;
        $display("FAIL flush_sr_d c=%0d: got %b want 0", c, sr_d_a); end
    end
  endtask

  task automatic test_basic();
    logic [WA-1:0] w, wd;
    w = 6'b101101;
    bus_a.in_valid = 1'b1; bus_a.in_data = w; bus_a.out_ready = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) begin bus_a.in_valid = 1'b0; bus_a.in_data = '0; end
      wd = w >> k;
      vectors++; if (sr_d_a !== wd[0]) begin miscompares++;
        $display("FAIL basic_sr_d k=%0d: got %b want %b", k, sr_d_a, wd[0]); end
      vectors++; if (bus_a.out_valid !== (k >= 12)) begin miscompares++;
        $display("FAIL basic_out_valid k=%0d: got %b want %b", k, bus_a.out_valid, k >= 12); end
    end
    vectors++; if (bus_a.out_data !== w) begin miscompares++;
      $display("FAIL basic_out_data: got %h want %h", bus_a.out_data, w); end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    vectors++; if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin miscompares++;
      $display("FAIL basic_release: got ov=%b ir=%b want ov=0 ir=1",
               bus_a.out_valid, bus_a.in_ready); end
  endtask

  task automatic test_stall();
    logic [WA-1:0] w;
    int lat;
    w = 6'b101101;
    bus_a.in_valid = 1'b1; bus_a.in_data = w; bus_a.out_ready = 1'b0;
    lat = -1;
    do begin
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      lat++;
    end while (bus_a.out_valid !== 1'b1 && lat < 40);
    vectors++; if (lat != WA + DA) begin miscompares++;
      $display("FAIL stall_latency: got %0d want %0d", lat, WA + DA); end
    for (int s = 1; s <= 5; s++) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = 6'h0F;
      @(negedge clk);
      vectors++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== w || bus_a.in_ready !== 1'b0)
      begin miscompares++;
        $display("FAIL stall_hold s=%0d: got ov=%b od=%h ir=%b want ov=1 od=%h ir=0",
                 s, bus_a.out_valid, bus_a.out_data, bus_a.in_ready, w); end
    end
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    vectors++; if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin miscompares++;
      $display("FAIL stall_release: got ir=%b ov=%b want ir=1 ov=0",
               bus_a.in_ready, bus_a.out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bus_a.in_valid = 1'b1; bus_a.in_data = 6'h15; bus_a.out_ready = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b0;
    end
    reset_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      vectors++; if (bus_a.out_valid !== 1'b0) begin miscompares++;
        $display("FAIL midrst_out_valid c=%0d: got %b want 0", c, bus_a.out_valid); end
      vectors++; if (bus_a.in_ready !== (c >= 7)) begin miscompares++;
        $display("FAIL midrst_in_ready c=%0d: got %b want %b", c, bus_a.in_ready, c >= 7); end
    end
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 6'h2A;
    lat = -1;
    do begin
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      lat++;
    end while (bus_a.out_valid !== 1'b1 && lat < 40);
    vectors++; if (lat != WA + DA || bus_a.out_data !== 6'h2A) begin miscompares++;
      $display("FAIL midrst_next_word: got lat=%0d od=%h want lat=%0d od=2a",
               lat, bus_a.out_data, WA + DA); end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t1, t_acc, t2;
    logic [WA-1:0] d1, d2;
    t1 = -1; t_acc = -1; t2 = -1; d1 = 'x; d2 = 'x;
    bus_a.in_valid = 1'b1; bus_a.in_data = 6'h00; bus_a.out_ready = 1'b1;
    for (int t = 1; t <= 60 && t2 < 0; t++) begin
      @(negedge clk);
      bus_a.in_data = 6'h3F;
      if (bus_a.out_valid === 1'b1) begin
        if (t1 < 0) begin t1 = t; d1 = bus_a.out_data; end
        else if (t_acc >= 0) begin t2 = t; d2 = bus_a.out_data; end
      end
      if (t_acc < 0 && bus_a.in_ready === 1'b1) t_acc = t;
    end
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    vectors++; if (t1 != WA + DA + 1 || d1 !== 6'h00) begin miscompares++;
      $display("FAIL b2b_first: got t=%0d od=%h want t=%0d od=00", t1, d1, WA + DA + 1); end
    vectors++; if (t_acc != t1 + 1) begin miscompares++;
      $display("FAIL b2b_accept: got t=%0d want %0d", t_acc, t1 + 1); end
    vectors++; if (t2 != t_acc + WA + DA + 1 || d2 !== 6'h3F) begin miscompares++;
      $display("FAIL b2b_second: got t=%0d od=%h want t=%0d od=3f",
               t2, d2, t_acc + WA + DA + 1); end
  endtask

  // Model: bit k of the word is driven after edge E0+k; word returns WIDTH+DEPTH edges later.
  task automatic test_random();
    logic [WA-1:0] w, wd;
    int idle, k;
    bit fin, rel;
    for (int n = 0; n < 40; n++) begin
      w = WA'($urandom);
      idle = $urandom_range(0, 3);
      repeat (idle) @(negedge clk);
      vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++;
        $display("FAIL rnd_idle_ready n=%0d: got %b want 1", n, bus_a.in_ready); end
      bus_a.in_valid = 1'b1; bus_a.in_data = w; bus_a.out_ready = 1'($urandom);
      k = 0; fin = 1'b0; rel = 1'b0;
      while (!fin) begin
        @(negedge clk);
        if (rel) begin
          vectors++; if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd_release n=%0d: got ov=%b ir=%b want ov=0 ir=1",
                     n, bus_a.out_valid, bus_a.in_ready); end
          bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
          fin = 1'b1;
        end else begin
          wd = w >> k;
          vectors++; if (sr_d_a !== wd[0]) begin miscompares++;
            $display("FAIL rnd_sr_d n=%0d k=%0d: got %b want %b", n, k, sr_d_a, wd[0]); end
          vectors++; if (bus_a.out_valid !== (k >= WA + DA) || bus_a.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_flags n=%0d k=%0d: got ov=%b ir=%b want ov=%b ir=0",
                     n, k, bus_a.out_valid, bus_a.in_ready, k >= WA + DA); end
          if (k >= WA + DA) begin
            vectors++; if (bus_a.out_data !== w) begin miscompares++;
              $display("FAIL rnd_out_data n=%0d: got %h want %h", n, bus_a.out_data, w); end
          end
          bus_a.in_valid  = 1'($urandom);
          bus_a.in_data   = WA'($urandom);
          bus_a.out_ready = (k >= WA + DA + 4) ? 1'b1 : 1'($urandom);
          rel = (k >= WA + DA) && bus_a.out_ready;
          k++;
          if (k > 60) begin
            miscompares++;
            $display("FAIL rnd_timeout n=%0d: got no release want release", n);
            fin = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_small_cfg();
    logic [WB-1:0] w, wd;
    w = 8'hA5;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clk);
      vectors++; if (bus_b.in_ready !== (c >= 4)) begin miscompares++;
        $display("FAIL small_flush c=%0d: got %b want %b", c, bus_b.in_ready, c >= 4); end
    end
    bus_b.in_valid = 1'b1; bus_b.in_data = w; bus_b.out_ready = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      wd = w >> k;
      vectors++; if (sr_d_b !== wd[0] || bus_b.out_valid !== (k >= 11)) begin miscompares++;
        $display("FAIL small_seq k=%0d: got sr=%b ov=%b want sr=%b ov=%b",
                 k, sr_d_b, bus_b.out_valid, wd[0], k >= 11); end
    end
    vectors++; if (bus_b.out_data !== w) begin miscompares++;
      $display("FAIL small_out_data: got %h want %h", bus_b.out_data, w); end
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.out_ready = 1'b0;
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_small_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
